// File: rtl/alu_uart_interface.sv
// Byte sequencer between the UART and the 8-bit ALU: collects A, B and op,
// presents them as registered ALU inputs and returns the result via a tx handshake.
module alu_uart_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_dato_A,
    output logic [DATA_WIDTH-1:0] o_dato_B,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        LATCH,
        WAIT_TX
    } state_t;

    state_t state, state_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= WAIT_A;
        else         state <= state_next;
    end

    // A tx_done arriving together with an rx byte in WAIT_TX wins; the byte is dropped.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (i_rx_done) state_next = WAIT_B;
            WAIT_B:  if (i_rx_done) state_next = WAIT_OP;
            WAIT_OP: if (i_rx_done) state_next = LATCH;
            LATCH:   state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Operands are held after a transaction so the ALU output stays stable.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_dato_A   <= '0;
            o_dato_B   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= (state == LATCH);
            case (state)
                WAIT_A:  if (i_rx_done) o_dato_A <= i_rx_data;
                WAIT_B:  if (i_rx_done) o_dato_B <= i_rx_data;
                WAIT_OP: if (i_rx_done) o_op <= i_rx_data[OP_WIDTH-1:0];
                LATCH:   o_tx_data <= i_alu_result;
                default: ;
            endcase
        end
    end

    assign o_busy = (state == LATCH) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a small behavioural ALU closing the loop.
module tb_alu_uart_interface;

    logic       clk, rst;
    logic [7:0] rx_data, alu_res, dato_a, dato_b, tx_data;
    logic       rx_done, tx_done, tx_start, busy;
    logic [5:0] op;
    int checks = 0;
    int errors = 0;

    alu_uart_interface #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_res), .i_tx_done(tx_done), .o_dato_A(dato_a),
        .o_dato_B(dato_b), .o_op(op), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU, combinational from the registered operands
    always_comb begin
        alu_res = 8'h00;
        case (op)
            6'h20: alu_res = dato_a + dato_b;
            6'h22: alu_res = dato_a - dato_b;
            6'h24: alu_res = dato_a & dato_b;
            6'h25: alu_res = dato_a | dato_b;
            6'h26: alu_res = dato_a ^ dato_b;
            6'h27: alu_res = ~(dato_a | dato_b);
            6'h03: alu_res = $signed(dato_a) >>> dato_b;
            6'h02: alu_res = dato_a >> dato_b;
            default: alu_res = 8'h00;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // first = rising edges after the op-tick edge until tx_start is seen (-1: never)
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                           output logic [7:0] txd, output int first, output int pulses);
        send_byte(a);
        send_byte(b);
        send_byte(o);
        first  = -1;
        pulses = 0;
        txd    = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_start) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    txd   = tx_data;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        checks++; if ({dato_a, dato_b, op, tx_data} !== 30'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {dato_a, dato_b, op, tx_data});
        end
        checks++; if ({tx_start, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00", {tx_start, busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [7:0] txd; int first, pulses;
        run_txn(8'h10, 8'h02, 8'h20, txd, first, pulses);
        checks++; if (dato_a !== 8'h10) begin errors++; $display("FAIL add_A: got %h expected 10", dato_a); end
        checks++; if (dato_b !== 8'h02) begin errors++; $display("FAIL add_B: got %h expected 02", dato_b); end
        checks++; if (op !== 6'h20) begin errors++; $display("FAIL add_op: got %h expected 20", op); end
        // Op tick at edge k, tx_start visible after edge k+1
        checks++; if (first !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL add_pulses: got %0d expected 1", pulses); end
        checks++; if (txd !== 8'h12) begin errors++; $display("FAIL add_tx: got %h expected 12", txd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", busy); end
        checks++; if (tx_data !== 8'h12) begin errors++; $display("FAIL add_tx_hold: got %h expected 12", tx_data); end
        finish_tx();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle: got %b expected 0", busy); end
    endtask

    task automatic test_logic_ops();
        logic [7:0] ops [5] = '{8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
        logic [7:0] exp [5] = '{8'h0E, 8'h00, 8'h12, 8'h12, 8'hED};
        logic [7:0] txd; int first, pulses;
        for (int i = 0; i < 5; i++) begin
            run_txn(8'h10, 8'h02, ops[i], txd, first, pulses);
            checks++; if (txd !== exp[i] || pulses !== 1) begin
                errors++; $display("FAIL op_%h: got %h x%0d expected %h x1", ops[i], txd, pulses, exp[i]);
            end
            finish_tx();
        end
    endtask

    task automatic test_shifts();
        logic [7:0] txd; int first, pulses;
        run_txn(8'h90, 8'h02, 8'h03, txd, first, pulses);
        checks++; if (txd !== 8'hE4) begin errors++; $display("FAIL sra: got %h expected e4", txd); end
        finish_tx();
        run_txn(8'h90, 8'h02, 8'h02, txd, first, pulses);
        checks++; if (txd !== 8'h24) begin errors++; $display("FAIL srl: got %h expected 24", txd); end
        finish_tx();
    endtask

    task automatic test_ignored_rx();
        logic [7:0] txd; int first, pulses; int extra;
        run_txn(8'h10, 8'h02, 8'hE0, txd, first, pulses);
        checks++; if (op !== 6'h20) begin errors++; $display("FAIL op_mask: got %h expected 20", op); end
        checks++; if (txd !== 8'h12) begin errors++; $display("FAIL op_mask_tx: got %h expected 12", txd); end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h55 + 8'(i));
            if (tx_start) extra++;
        end
        checks++; if ({dato_a, dato_b, op} !== {8'h10, 8'h02, 6'h20}) begin
            errors++; $display("FAIL busy_rx_regs: got %h expected %h", {dato_a, dato_b, op}, {8'h10, 8'h02, 6'h20});
        end
        checks++; if (extra !== 0 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_rx_ctrl: got extra=%0d busy=%b expected 0/1", extra, busy);
        end
        // rx and tx_done together: back to WAIT_A, byte not taken as A
        rx_data = 8'h77; rx_done = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; tx_done = 1'b0;
        checks++; if (busy !== 1'b0 || dato_a !== 8'h10) begin
            errors++; $display("FAIL simul_done: got busy=%b A=%h expected 0/10", busy, dato_a);
        end
        run_txn(8'h05, 8'h03, 8'h20, txd, first, pulses);
        checks++; if (txd !== 8'h08 || dato_a !== 8'h05) begin
            errors++; $display("FAIL simul_next: got tx=%h A=%h expected 08/05", txd, dato_a);
        end
        finish_tx();
    endtask

    task automatic test_reset_mid();
        logic [7:0] txd; int first, pulses;
        send_byte(8'h33);
        send_byte(8'h44);
        #2 rst = 1'b1;
        #1;
        checks++; if ({dato_a, dato_b, op, tx_data, tx_start, busy} !== 32'h0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", {dato_a, dato_b, op, tx_data, tx_start, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn(8'h01, 8'h02, 8'h20, txd, first, pulses);
        checks++; if (txd !== 8'h03 || first !== 1 || pulses !== 1) begin
            errors++; $display("FAIL reset_fresh: got tx=%h first=%0d n=%0d expected 03/1/1", txd, first, pulses);
        end
        finish_tx();
    endtask

    task automatic test_stray_tx_done();
        finish_tx();
        checks++; if (busy !== 1'b0 || dato_a !== 8'h01) begin
            errors++; $display("FAIL txdone_wait_a: got busy=%b A=%h expected 0/01", busy, dato_a);
        end
        send_byte(8'h20);
        finish_tx();
        send_byte(8'h07);
        send_byte(8'h20);
        // now in LATCH
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h27) begin
            errors++; $display("FAIL txdone_latch: got start=%b tx=%h expected 1/27", tx_start, tx_data);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++; $display("FAIL txdone_wait_tx: got busy=%b start=%b expected 1/0", busy, tx_start);
        end
        finish_tx();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL txdone_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] txd; int first, pulses;
        run_txn(8'h40, 8'h01, 8'h22, txd, first, pulses);
        finish_tx();
        // rx tick sampled on the edge right after tx_done
        run_txn(8'hAA, 8'h0F, 8'h24, txd, first, pulses);
        checks++; if (dato_a !== 8'hAA || txd !== 8'h0A) begin
            errors++; $display("FAIL back_to_back: got A=%h tx=%h expected aa/0a", dato_a, txd);
        end
        finish_tx();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_ops();
        test_shifts();
        test_ignored_rx();
        test_reset_mid();
        test_stray_tx_done();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
